// File: rtl/grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// grn_attractor_ctrl
//
// Sequencer for an array of N_NODES gene-regulatory-network node cells. Each
// node carries a slow (s0) and a fast (s1) copy of its state. For every
// initial state 0 .. 2^N_NODES-1 the controller loads the array, runs Floyd
// cycle detection, and reports two values through a valid/ready port:
//   - meet count: step pairs until the two trajectories coincide
//   - period:     fast-only steps until they coincide again
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle pulse; starts a sweep from IDLE or DONE
//   apc_s0, apc_s1       slow / fast trajectory states from the node array
//   reset_nos            loads init_state into both copies of every node
//   start_s0, start_s1   slow / fast advance requests to the node array
//   init_state           initial state driven to the nodes (sweep index)
//   res_valid/res_ready  result handshake
//   res_init             initial state the result belongs to
//   res_meet             meet count
//   res_period           attractor period
//   res_timeout          a counter saturated; meet/period are not meaningful
//   busy                 sweep in progress
//   done                 sweep finished; held until the next start
// ---------------------------------------------------------------------------
module grn_attractor_ctrl #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] apc_s0,
  input  logic [N_NODES-1:0] apc_s1,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [CNT_W-1:0]   res_meet,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP1,
    CMP1,
    STEP2,
    CMP2,
    EMIT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [N_NODES-1:0] init_idx;
  logic [CNT_W-1:0]   meet_cnt;
  logic [CNT_W-1:0]   per_cnt;
  logic               sub_phase;
  logic               timeout_nx;
  logic               xfer;
  logic               traj_eq;
  logic               last_init;

  assign xfer       = res_valid & res_ready;
  assign traj_eq    = (apc_s0 == apc_s1);
  assign last_init  = &init_idx;
  assign init_state = init_idx;

  // Next-state decode. STEP1 runs twice per comparison (sub_phase selects
  // which half of the pair we are in) so the fast copy moves two steps for
  // every step of the slow copy. timeout_nx flags an exit to EMIT caused by
  // a saturated counter rather than a trajectory match.
  always_comb begin
    state_nx   = state;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = STEP1;
      end
      STEP1: begin
        if (sub_phase) state_nx = CMP1;
        else           state_nx = STEP1;
      end
      CMP1: begin
        if (traj_eq) begin
          state_nx = STEP2;
        end else if (meet_cnt == CNT_MAX) begin
          timeout_nx = 1'b1;
          state_nx   = EMIT;
        end else begin
          state_nx = STEP1;
        end
      end
      STEP2: begin
        state_nx = CMP2;
      end
      CMP2: begin
        if (traj_eq) begin
          state_nx = EMIT;
        end else if (per_cnt == CNT_MAX) begin
          timeout_nx = 1'b1;
          state_nx   = EMIT;
        end else begin
          state_nx = STEP2;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_init) state_nx = DONE;
          else           state_nx = LOAD;
        end
      end
      DONE: begin
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, counters and result capture. Control outputs are
  // decoded from the next state and registered, so each pulse lines up
  // exactly with the cycle spent in the corresponding state and the node
  // array sees glitch-free controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      init_idx    <= '0;
      meet_cnt    <= '0;
      per_cnt     <= '0;
      sub_phase   <= 1'b0;
      reset_nos   <= 1'b0;
      start_s0    <= 1'b0;
      start_s1    <= 1'b0;
      res_valid   <= 1'b0;
      res_init    <= '0;
      res_meet    <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_nx;
      reset_nos <= (state_nx == LOAD);
      start_s0  <= (state_nx == STEP1);
      start_s1  <= (state_nx == STEP1) || (state_nx == STEP2);
      res_valid <= (state_nx == EMIT);
      busy      <= (state_nx != IDLE) && (state_nx != DONE);
      done      <= (state_nx == DONE);

      // Sweep index: restart on an accepted start, advance on each
      // accepted result except the last one of the sweep.
      if ((state == IDLE || state == DONE) && start) begin
        init_idx <= '0;
      end else if (xfer && !last_init) begin
        init_idx <= init_idx + N_NODES'(1);
      end

      // The meet counter counts completed step pairs, so it only moves on
      // the second STEP1 of each pair. Both counters hold at full scale.
      if (state == STEP1) begin
        sub_phase <= ~sub_phase;
        if (sub_phase && (meet_cnt != CNT_MAX)) begin
          meet_cnt <= meet_cnt + CNT_W'(1);
        end
      end

      if ((state == STEP2) && (per_cnt != CNT_MAX)) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end

      if (state_nx == LOAD) begin
        meet_cnt  <= '0;
        per_cnt   <= '0;
        sub_phase <= 1'b0;
      end

      // Result fields are latched once on entry to EMIT and then held
      // untouched for as long as the consumer stalls.
      if ((state_nx == EMIT) && (state != EMIT)) begin
        res_init    <= init_idx;
        res_meet    <= meet_cnt;
        res_period  <= per_cnt;
        res_timeout <= timeout_nx;
      end
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grn_attractor_ctrl
//
// Self-checking bench for grn_attractor_ctrl with N_NODES=4, CNT_W=4. A small
// behavioural node array (hold, rotate-left, or never-meeting trajectories)
// drives apc_s0/apc_s1. Expected results are queued when a sweep is issued
// and a monitor pops and compares them on every accepted result.
// ---------------------------------------------------------------------------
module tb_grn_attractor_ctrl;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         start     = 1'b0;
  logic         res_ready = 1'b1;
  logic [N-1:0] apc_s0;
  logic [N-1:0] apc_s1;
  logic         reset_nos;
  logic         start_s0;
  logic         start_s1;
  logic [N-1:0] init_state;
  logic         res_valid;
  logic [N-1:0] res_init;
  logic [W-1:0] res_meet;
  logic [W-1:0] res_period;
  logic         res_timeout;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // 0: nodes hold their state, 1: rotate-left network, 2: s1 forced to ~s0
  int net_mode = 0;

  logic [N-1:0] node_s0 = '0;
  logic [N-1:0] node_s1 = '0;
  logic         node_ph = 1'b0;

  typedef struct {
    logic [N-1:0] init;
    logic [W-1:0] meet;
    logic [W-1:0] period;
    logic         timeout;
  } exp_t;

  exp_t exp_q[$];

  // Cycle length of each 4-bit pattern under rotate-left, worked out by hand.
  int rot_period [16] = '{1, 4, 4, 4, 4, 2, 4, 4, 4, 4, 2, 4, 4, 4, 4, 1};

  always #5 clk = ~clk;

  grn_attractor_ctrl #(
    .N_NODES(N),
    .CNT_W  (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .apc_s0     (apc_s0),
    .apc_s1     (apc_s1),
    .reset_nos  (reset_nos),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .init_state (init_state),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_init   (res_init),
    .res_meet   (res_meet),
    .res_period (res_period),
    .res_timeout(res_timeout),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [N-1:0] net_next(input logic [N-1:0] x);
    if (net_mode == 1) return {x[N-2:0], x[N-1]};
    return x;
  endfunction

  // Behavioural node array: the slow copy advances on every second
  // start_s0 after a load, the fast copy on every start_s1.
  always @(posedge clk) begin
    if (reset_nos) begin
      node_s0 <= init_state;
      node_s1 <= init_state;
      node_ph <= 1'b0;
    end else begin
      if (start_s1) node_s1 <= net_next(node_s1);
      if (start_s0) begin
        node_ph <= ~node_ph;
        if (node_ph) node_s0 <= net_next(node_s0);
      end
    end
  end

  assign apc_s0 = node_s0;
  assign apc_s1 = (net_mode == 2) ? ~node_s0 : node_s1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: control exclusivity every cycle, scoreboard pop on transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      checkOutput("ctrl_exclusive", 32'(reset_nos && (start_s0 || start_s1)), 32'd0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("pending_results", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_init",    32'(res_init),    32'(e.init));
          checkOutput("res_meet",    32'(res_meet),    32'(e.meet));
          checkOutput("res_period",  32'(res_period),  32'(e.period));
          checkOutput("res_timeout", 32'(res_timeout), 32'(e.timeout));
        end
      end
    end
  end

  // Queue the expected results for inits 0..last_idx, then pulse start.
  task automatic applyStimulus(input int mode, input int last_idx);
    exp_t e;
    for (int i = 0; i <= last_idx; i++) begin
      e.init = N'(i);
      case (mode)
        1: begin
          e.meet    = W'(rot_period[i]);
          e.period  = W'(rot_period[i]);
          e.timeout = 1'b0;
        end
        2: begin
          e.meet    = 4'd15;
          e.period  = 4'd0;
          e.timeout = 1'b1;
        end
        default: begin
          e.meet    = 4'd1;
          e.period  = 4'd1;
          e.timeout = 1'b0;
        end
      endcase
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_reset_nos"},   32'(reset_nos),   32'd0);
    checkOutput({pfx, "_start_s0"},    32'(start_s0),    32'd0);
    checkOutput({pfx, "_start_s1"},    32'(start_s1),    32'd0);
    checkOutput({pfx, "_init_state"},  32'(init_state),  32'd0);
    checkOutput({pfx, "_res_valid"},   32'(res_valid),   32'd0);
    checkOutput({pfx, "_res_init"},    32'(res_init),    32'd0);
    checkOutput({pfx, "_res_meet"},    32'(res_meet),    32'd0);
    checkOutput({pfx, "_res_period"},  32'(res_period),  32'd0);
    checkOutput({pfx, "_res_timeout"}, 32'(res_timeout), 32'd0);
    checkOutput({pfx, "_busy"},        32'(busy),        32'd0);
    checkOutput({pfx, "_done"},        32'(done),        32'd0);
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_all_results"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    // Hold network sweep, with a stray start while busy
    net_mode = 0;
    applyStimulus(0, 15);
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("busy_mid_sweep", 32'(busy), 32'd1);
    waitDone("hold1", 1000);
    repeat (3) @(negedge clk);
    checkOutput("done_held", 32'(done), 32'd1);

    // Start from DONE repeats the identical sweep
    applyStimulus(0, 15);
    @(negedge clk);
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_restart", 32'(busy), 32'd1);
    waitDone("hold2", 1000);

    // Rotate-left network with backpressure on the first result
    net_mode  = 1;
    res_ready = 1'b0;
    applyStimulus(1, 15);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 32'(res_valid),   32'd1);
      checkOutput("bp_res_init",   32'(res_init),    32'd0);
      checkOutput("bp_res_meet",   32'(res_meet),    32'd1);
      checkOutput("bp_res_period", 32'(res_period),  32'd1);
      checkOutput("bp_res_to",     32'(res_timeout), 32'd0);
      checkOutput("bp_no_ctrl",    32'(reset_nos | start_s0 | start_s1), 32'd0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_load_after_xfer", 32'(reset_nos),  32'd1);
    checkOutput("bp_valid_dropped",   32'(res_valid),  32'd0);
    checkOutput("bp_next_init",       32'(init_state), 32'd1);
    waitDone("rotate", 2000);

    // Trajectories that never meet saturate the meet counter
    net_mode = 2;
    applyStimulus(2, 15);
    waitDone("timeout", 4000);

    // Reset during STEP2 of init 7 aborts the sweep
    net_mode = 0;
    applyStimulus(0, 6);
    n = 0;
    while (!(start_s1 && !start_s0 && init_state == 4'd7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("step2_init7_found", 32'(start_s1 && !start_s0 && init_state == 4'd7), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    checkOutput("abort_results", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_stays_idle", 32'(busy | done), 32'd0);

    // Fresh sweep after the abort starts again at init 0
    applyStimulus(0, 15);
    waitDone("after_abort", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
